// File: rtl/sdma_chan_arbiter.sv
// Round-robin arbiter sharing one QLAL4S3B SDMA channel among NUM_REQ requesters,
// sequencing SDMA_Req/Active/Done and flagging stalled transfers with a sticky interrupt.
module sdma_chan_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                       WB_CLK,
  input  logic                       WB_RSTn,
  input  logic                       Enable_i,
  input  logic [NUM_REQ-1:0]         Req_i,
  output logic [NUM_REQ-1:0]         Grant_o,
  output logic [NUM_REQ-1:0]         Done_o,
  output logic                       SDMA_Req_o,
  input  logic                       SDMA_Active_i,
  input  logic                       SDMA_Done_i,
  output logic                       Busy_o,
  output logic                       Timeout_Intr_o,
  output logic [$clog2(NUM_REQ)-1:0] Timeout_Id_o,
  input  logic                       Intr_Clr_i
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] last;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [IDW-1:0] win;
  logic           found;
  logic           expire;
  logic           progress;
  logic           abort;

  assign Busy_o   = (state != S_IDLE);
  assign cnt_nxt  = cnt + CW'(1);
  assign expire   = (cnt_nxt == CW'(TIMEOUT_CYCLES - 1));
  assign progress = SDMA_Done_i || ((state == S_REQ) && SDMA_Active_i);
  assign abort    = ((state == S_REQ) || (state == S_ACTIVE)) && !progress && expire;

  // Search starts one past the previous winner and wraps, so every requester gets a turn.
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && Req_i[IDW'((int'(last) + i) % NUM_REQ)]) begin
        found = 1'b1;
        win   = IDW'((int'(last) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state          <= S_IDLE;
      last           <= IDW'(NUM_REQ - 1);
      cnt            <= '0;
      Grant_o        <= '0;
      Done_o         <= '0;
      SDMA_Req_o     <= 1'b0;
      Timeout_Intr_o <= 1'b0;
      Timeout_Id_o   <= '0;
    end else begin
      Done_o <= '0;
      if (Intr_Clr_i) Timeout_Intr_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Enable_i && found) begin
            Grant_o    <= NUM_REQ'(1) << win;
            SDMA_Req_o <= 1'b1;
            last       <= win;
            cnt        <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (SDMA_Done_i) begin
            SDMA_Req_o <= 1'b0;
            Done_o     <= Grant_o;
            state      <= S_DONE;
          end else if (SDMA_Active_i) begin
            SDMA_Req_o <= 1'b0;
            cnt        <= '0;
            state      <= S_ACTIVE;
          end else if (!expire) begin
            cnt <= cnt_nxt;
          end
        end
        S_ACTIVE: begin
          if (SDMA_Done_i) begin
            Done_o <= Grant_o;
            state  <= S_DONE;
          end else if (!expire) begin
            cnt <= cnt_nxt;
          end
        end
        S_DONE: begin
          Grant_o <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Placed after the clear so a coincident timeout leaves the flag set.
      if (abort) begin
        Grant_o        <= '0;
        SDMA_Req_o     <= 1'b0;
        Timeout_Intr_o <= 1'b1;
        Timeout_Id_o   <= last;
        state          <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sdma_chan_arbiter.sv
// Scoreboard bench for sdma_chan_arbiter: stimulus queues expected grants, done pulses
// and timeout ids; a negedge monitor pops and compares them as the DUT produces them.
module tb_sdma_chan_arbiter;

  logic       WB_CLK;
  logic       WB_RSTn;
  logic       Enable_i;
  logic [2:0] Req_i;
  logic [2:0] Grant_o;
  logic [2:0] Done_o;
  logic       SDMA_Req_o;
  logic       SDMA_Active_i;
  logic       SDMA_Done_i;
  logic       Busy_o;
  logic       Timeout_Intr_o;
  logic [1:0] Timeout_Id_o;
  logic       Intr_Clr_i;

  int tests = 0;
  int fails = 0;

  logic [2:0] grant_q[$];
  logic [2:0] done_q[$];
  logic [1:0] to_q[$];

  logic [2:0] prev_grant = '0;
  logic       prev_intr  = 1'b0;

  sdma_chan_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .WB_CLK         (WB_CLK),
    .WB_RSTn        (WB_RSTn),
    .Enable_i       (Enable_i),
    .Req_i          (Req_i),
    .Grant_o        (Grant_o),
    .Done_o         (Done_o),
    .SDMA_Req_o     (SDMA_Req_o),
    .SDMA_Active_i  (SDMA_Active_i),
    .SDMA_Done_i    (SDMA_Done_i),
    .Busy_o         (Busy_o),
    .Timeout_Intr_o (Timeout_Intr_o),
    .Timeout_Id_o   (Timeout_Id_o),
    .Intr_Clr_i     (Intr_Clr_i)
  );

  initial begin
    WB_CLK = 1'b0;
    forever #5 WB_CLK = ~WB_CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge WB_CLK);
    #1;
  endtask

  // Called just after the grant edge; answers with Active after a cycles, Done after d.
  task automatic serve(input int a, input int d, input logic [2:0] own);
    step(a);
    SDMA_Active_i = 1'b1;
    step(1);
    SDMA_Active_i = 1'b0;
    chk("act_req_drop", int'(SDMA_Req_o), 0);
    step(d - a - 1);
    done_q.push_back(own);
    SDMA_Done_i = 1'b1;
    step(1);
    SDMA_Done_i = 1'b0;
    chk("done_grant_held", int'(Grant_o), int'(own));
    step(1);
    chk("idle_gap", int'(Grant_o), 0);
  endtask

  always @(negedge WB_CLK) begin
    if (Grant_o != 3'b000 && prev_grant == 3'b000) begin
      if (grant_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL grant_unexpected: got %b required none", Grant_o);
      end else begin
        chk("grant", int'(Grant_o), int'(grant_q.pop_front()));
      end
    end
    if (Done_o != 3'b000) begin
      if (done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: got %b required none", Done_o);
      end else begin
        chk("done", int'(Done_o), int'(done_q.pop_front()));
      end
    end
    if (Timeout_Intr_o && !prev_intr) begin
      if (to_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL timeout_unexpected: got id %0d required none", Timeout_Id_o);
      end else begin
        chk("timeout_id", int'(Timeout_Id_o), int'(to_q.pop_front()));
      end
    end
    prev_grant <= Grant_o;
    prev_intr  <= Timeout_Intr_o;
  end

  initial begin
    WB_RSTn       = 1'b0;
    Enable_i      = 1'b1;
    Req_i         = 3'b111;
    SDMA_Active_i = 1'b0;
    SDMA_Done_i   = 1'b0;
    Intr_Clr_i    = 1'b0;

    // Reset holds everything low even with all requests pending
    step(3);
    chk("rst_grant", int'(Grant_o), 0);
    chk("rst_done", int'(Done_o), 0);
    chk("rst_sdma_req", int'(SDMA_Req_o), 0);
    chk("rst_busy", int'(Busy_o), 0);
    chk("rst_intr", int'(Timeout_Intr_o), 0);
    chk("rst_id", int'(Timeout_Id_o), 0);
    grant_q.push_back(3'b001);
    WB_RSTn = 1'b1;
    step(1);
    chk("first_grant", int'(Grant_o), 1);
    chk("first_sdma_req", int'(SDMA_Req_o), 1);
    chk("first_busy", int'(Busy_o), 1);

    // Round-robin rotation 001, 010, 100, 001
    serve(2, 5, 3'b001);
    grant_q.push_back(3'b010);
    step(1);
    serve(2, 5, 3'b010);
    grant_q.push_back(3'b100);
    step(1);
    serve(2, 5, 3'b100);
    grant_q.push_back(3'b001);
    step(1);
    serve(2, 5, 3'b001);

    // Timeout: grant held 15 cycles, then abort with id 1 and no done pulse
    Req_i = 3'b010;
    grant_q.push_back(3'b010);
    to_q.push_back(2'd1);
    step(1);
    Req_i = 3'b000;
    for (int i = 0; i < 15; i++) begin
      chk("to_grant_held", int'(Grant_o), 2);
      step(1);
    end
    chk("to_grant_clear", int'(Grant_o), 0);
    chk("to_sdma_req", int'(SDMA_Req_o), 0);
    chk("to_busy", int'(Busy_o), 0);
    chk("to_intr_set", int'(Timeout_Intr_o), 1);
    chk("to_id", int'(Timeout_Id_o), 1);
    Intr_Clr_i = 1'b1;
    step(1);
    Intr_Clr_i = 1'b0;
    chk("to_intr_clr", int'(Timeout_Intr_o), 0);
    chk("to_id_hold", int'(Timeout_Id_o), 1);

    // Timeout coinciding with clear: set wins
    Req_i = 3'b001;
    grant_q.push_back(3'b001);
    to_q.push_back(2'd0);
    step(1);
    Req_i = 3'b000;
    step(14);
    Intr_Clr_i = 1'b1;
    step(1);
    Intr_Clr_i = 1'b0;
    chk("setwin_intr", int'(Timeout_Intr_o), 1);
    chk("setwin_id", int'(Timeout_Id_o), 0);
    chk("setwin_grant", int'(Grant_o), 0);
    Intr_Clr_i = 1'b1;
    step(1);
    Intr_Clr_i = 1'b0;
    chk("setwin_clr", int'(Timeout_Intr_o), 0);

    // Active/Done while idle are ignored
    SDMA_Active_i = 1'b1;
    SDMA_Done_i   = 1'b1;
    step(1);
    SDMA_Active_i = 1'b0;
    SDMA_Done_i   = 1'b0;
    chk("idle_ignore_busy", int'(Busy_o), 0);
    chk("idle_ignore_done", int'(Done_o), 0);

    // Early done in REQ without Active
    Req_i = 3'b100;
    grant_q.push_back(3'b100);
    step(1);
    Req_i = 3'b000;
    chk("early_sdma_req", int'(SDMA_Req_o), 1);
    step(1);
    done_q.push_back(3'b100);
    SDMA_Done_i = 1'b1;
    step(1);
    SDMA_Done_i = 1'b0;
    chk("early_req_drop", int'(SDMA_Req_o), 0);
    chk("early_done", int'(Done_o), 4);
    chk("early_no_intr", int'(Timeout_Intr_o), 0);
    step(1);
    chk("early_grant_clr", int'(Grant_o), 0);
    chk("early_busy", int'(Busy_o), 0);

    // Enable drop and owner request drop mid-transfer
    Req_i = 3'b111;
    grant_q.push_back(3'b001);
    step(1);
    step(1);
    SDMA_Active_i = 1'b1;
    step(1);
    SDMA_Active_i = 1'b0;
    chk("en_active_req", int'(SDMA_Req_o), 0);
    Enable_i = 1'b0;
    Req_i    = 3'b110;
    step(2);
    done_q.push_back(3'b001);
    SDMA_Done_i = 1'b1;
    step(1);
    SDMA_Done_i = 1'b0;
    chk("en_grant_held", int'(Grant_o), 1);
    step(1);
    chk("en_grant_clr", int'(Grant_o), 0);
    Req_i = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("en_no_grant", int'(Grant_o), 0);
      chk("en_not_busy", int'(Busy_o), 0);
    end
    Enable_i = 1'b1;
    grant_q.push_back(3'b010);
    step(1);
    chk("en_resume", int'(Grant_o), 2);
    serve(2, 5, 3'b010);

    // Asynchronous reset during ACTIVE
    grant_q.push_back(3'b100);
    step(1);
    chk("mr_grant", int'(Grant_o), 4);
    step(1);
    SDMA_Active_i = 1'b1;
    step(1);
    SDMA_Active_i = 1'b0;
    #3;
    WB_RSTn = 1'b0;
    #1;
    chk("mr_grant_low", int'(Grant_o), 0);
    chk("mr_sdma_req_low", int'(SDMA_Req_o), 0);
    chk("mr_busy_low", int'(Busy_o), 0);
    step(2);
    grant_q.push_back(3'b001);
    WB_RSTn = 1'b1;
    step(1);
    chk("mr_regrant", int'(Grant_o), 1);
    Req_i = 3'b000;
    serve(2, 5, 3'b001);

    step(2);
    chk("grant_q_empty", grant_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("to_q_empty", to_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
